spi_boot_loader: RTL and testbench
==================================

// Module: spi_boot_loader
// PURPOSE
//  Boot-time SPI flash copier feeding the boot ROM / main memory write port.
//  On start, issues a flash READ (0x03) command, streams NWORDS 16-bit words
//  MSB-first from flash and writes each into memory over the cs/we/addr/din bus.
//  Sits between the SPI pins and the memory write port; the CPU is held off until done.
// PARAMETERS
//  ADDR_W     4          width of mem_addr
//  NWORDS     8          words copied per transfer (1..2**ADDR_W)
//  MEM_BASE   0          first memory word address written
//  FLASH_ADDR 24'h000000 24-bit flash byte address sent after the command
//  CLK_DIV    2          SCK half-period in clk cycles (>=1)
// PORTS
//  clk       in   1       system clock, all logic on posedge
//  rst_n     in   1       asynchronous active-low reset
//  start     in   1       begin transfer; sampled only in IDLE
//  busy      out  1       high from the cycle after start is accepted until DONE
//  done      out  1       one-cycle pulse after the last memory write
//  spi_sck   out  1       SPI clock, mode 0 (idle low)
//  spi_cs_n  out  1       flash chip select, active low
//  spi_mosi  out  1       serial data to flash
//  spi_miso  in   1       serial data from flash
//  mem_cs    out  1       memory select, one-cycle write pulse
//  mem_we    out  1       memory write enable, asserted together with mem_cs
//  mem_addr  out  ADDR_W  memory word address
//  mem_din   out  16      word written to memory
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; spi_cs_n=1, spi_sck=0, spi_mosi=0, busy=0,
//   done=0, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0; bit/word counters cleared.
//  FSM: IDLE -> CMD -> READ -> WRITE -> (READ | FINISH) -> IDLE.
//  IDLE: start=1 -> CMD next cycle, spi_cs_n=0, busy=1. start=0 -> stay.
//  CMD: shift out 32 bits {8'h03, FLASH_ADDR} MSB first; 32 SCK pulses.
//  READ: 16 SCK pulses; spi_miso sampled on each SCK rising edge into shift reg.
//  SPI timing: SCK toggles every CLK_DIV clk cycles; MOSI updates on falling edge
//   (first bit valid when cs_n falls); in READ, MOSI held 0.
//  WRITE: exactly one cycle, entered the clk cycle after the 16th READ sample:
//   mem_cs=1, mem_we=1, mem_addr=MEM_BASE+index (mod 2**ADDR_W), mem_din=word.
//   SCK held low during WRITE; cs_n stays low so the flash stream continues.
//  After write of index NWORDS-1 -> FINISH: spi_cs_n=1, done=1 for one cycle,
//   busy=0 in the same cycle, then IDLE. Otherwise index++ and back to READ.
//  mem_cs/mem_we are 0 in every state except WRITE; mem_addr/mem_din hold last value.
//  start while busy is ignored; start held high in IDLE after done starts a new transfer.
//  Reset mid-transfer: outputs return to reset values immediately; no partial
//   word is ever written; after rst_n rises block waits in IDLE for start.
//  Latency: start -> first mem write = 1 + (32+16)*2*CLK_DIV + 1 cycles.
// TESTING
//  1 Reset: rst_n=0 -> cs_n=1, sck=0, mosi=0, mem_cs=mem_we=0, busy=done=0.
//  2 Flash model words 0x1234,0xABCD,... start pulse -> MOSI bytes 03 00 00 00;
//    writes addr 0..7 data 0x1234,0xABCD,...; one-cycle done; cs_n=1 after.
//  3 CLK_DIV=1 and 4 -> SCK period 2 and 8 clk; start->first write 98 / 386 cycles.
//  4 start pulsed again while busy -> ignored; exactly NWORDS writes, one done.
//  5 rst_n low during READ word 3 -> cs_n=1 and mem_we=0 at once; no write of word 3;
//    new start -> full transfer from FLASH_ADDR, addr MEM_BASE.
//  6 NWORDS=1, MEM_BASE=15, miso=1 -> single write addr 15 data 0xFFFF, then done.

Source files
------------

// File: rtl/spi_boot_loader.sv
// spi_boot_loader
//   Boot-time copier from SPI flash into a memory write port. On start it
//   lowers chip select and sends the READ command (0x03) with a 24-bit flash
//   address. It then reads NWORDS 16-bit words MSB-first. After each word it
//   issues a single-cycle memory write and moves on to the next word.
//
// Ports
//   clk, rst_n          system clock (posedge), asynchronous active-low reset
//   start               begin a transfer (only looked at while idle)
//   busy / done         transfer in progress / one-cycle completion pulse
//   spi_sck, spi_cs_n   SPI mode-0 clock and active-low chip select
//   spi_mosi, spi_miso  serial data to / from the flash
//   mem_cs, mem_we      one-cycle memory write strobe pair
//   mem_addr, mem_din   memory word address and write data (held between writes)
module spi_boot_loader #(
    parameter int          ADDR_W     = 4,
    parameter int          NWORDS     = 8,
    parameter int          MEM_BASE   = 0,
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter int          CLK_DIV    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              spi_sck,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int               IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [31:0]      CMD_WORD = {8'h03, FLASH_ADDR};
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_READ,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    // Command bits still to be sent; bit 31 goes straight to MOSI at start.
    logic [30:0]        shout_q, shout_d;
    logic [15:0]        shin_q, shin_d;
    logic               sck_q, sck_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mem_cs_q, mem_cs_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [15:0]        mem_din_q, mem_din_d;
    logic               sck_tick;

    // One half SCK period has elapsed.
    assign sck_tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            shout_q    <= '0;
            shin_q     <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            shout_q    <= shout_d;
            shin_q     <= shin_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        idx_d      = idx_q;
        shout_d    = shout_q;
        shin_d     = shin_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mem_cs_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CMD;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    // First command bit must be valid as soon as cs_n falls.
                    mosi_d  = CMD_WORD[31];
                    shout_d = CMD_WORD[30:0];
                    sck_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    idx_d   = '0;
                end
            end

            S_CMD, S_READ: begin
                if (!sck_tick) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising edge: capture flash data (command phase ignores MISO).
                        if (state_q == S_READ) begin
                            shin_d = {shin_q[14:0], spi_miso};
                        end
                    end else begin
                        // Falling edge: one bit period complete.
                        bit_d = bit_q + 5'd1;
                        if (state_q == S_CMD) begin
                            mosi_d  = shout_q[30];
                            shout_d = {shout_q[29:0], 1'b0};
                            if (bit_q == 5'd31) begin
                                state_d = S_READ;
                                bit_d   = '0;
                                mosi_d  = 1'b0;
                            end
                        end else if (bit_q == 5'd15) begin
                            state_d = S_WRITE;
                            bit_d   = '0;
                        end
                    end
                end
            end

            S_WRITE: begin
                // SCK is already low here; cs_n stays low so the flash keeps streaming.
                mem_cs_d   = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = ADDR_W'(MEM_BASE + int'(idx_q));
                mem_din_d  = shin_q;
                div_d      = '0;
                if (idx_q == IDX_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_READ;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;
    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
`timescale 1ns/1ps
module tb_spi_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // main instance: 8 words, base 0, CLK_DIV 2
    logic        start = 1'b0;
    logic        busy, done, sck, cs_n, mosi, mem_cs, mem_we;
    logic        miso = 1'b0;
    logic [3:0]  mem_addr;
    logic [15:0] mem_din;

    // CLK_DIV=1 and CLK_DIV=4 instances, MISO tied low
    logic        st1 = 1'b0, st4 = 1'b0;
    logic        b1, dn1, sck1, csn1, mosi1, mcs1, mwe1;
    logic        b4, dn4, sck4, csn4, mosi4, mcs4, mwe4;
    logic [3:0]  ma1, ma4;
    logic [15:0] md1, md4;

    // single-word instance at address 15, MISO tied high
    logic        st6 = 1'b0;
    logic        b6, dn6, sck6, csn6, mosi6, mcs6, mwe6;
    logic [3:0]  ma6;
    logic [15:0] md6;

    spi_boot_loader #(.ADDR_W(4), .NWORDS(8), .MEM_BASE(0), .FLASH_ADDR(24'h000000), .CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din));

    spi_boot_loader #(.ADDR_W(4), .NWORDS(8), .MEM_BASE(0), .FLASH_ADDR(24'h000000), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .busy(b1), .done(dn1),
        .spi_sck(sck1), .spi_cs_n(csn1), .spi_mosi(mosi1), .spi_miso(1'b0),
        .mem_cs(mcs1), .mem_we(mwe1), .mem_addr(ma1), .mem_din(md1));

    spi_boot_loader #(.ADDR_W(4), .NWORDS(8), .MEM_BASE(0), .FLASH_ADDR(24'h000000), .CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .busy(b4), .done(dn4),
        .spi_sck(sck4), .spi_cs_n(csn4), .spi_mosi(mosi4), .spi_miso(1'b0),
        .mem_cs(mcs4), .mem_we(mwe4), .mem_addr(ma4), .mem_din(md4));

    spi_boot_loader #(.ADDR_W(4), .NWORDS(1), .MEM_BASE(15), .FLASH_ADDR(24'h000000), .CLK_DIV(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(st6), .busy(b6), .done(dn6),
        .spi_sck(sck6), .spi_cs_n(csn6), .spi_mosi(mosi6), .spi_miso(1'b1),
        .mem_cs(mcs6), .mem_we(mwe6), .mem_addr(ma6), .mem_din(md6));

    // Flash model: the word stream begins on the falling edge after the
    // 32nd command bit, MSB-first, advancing one bit per falling edge.
    logic [15:0] fw [8];
    int          rises   = 0;
    int          cmd_cnt = 0;
    int          fj;
    logic [31:0] cmd_sh   = '0;
    logic [31:0] cmd_last = '0;

    always @(posedge sck or negedge sck or posedge cs_n) begin
        if (cs_n === 1'b1) begin
            rises = 0;
            miso  = 1'b0;
        end else if (sck === 1'b1) begin
            if (rises < 32) cmd_sh = {cmd_sh[30:0], mosi};
            rises++;
            if (rises == 32) begin
                cmd_last = cmd_sh;
                cmd_cnt++;
            end
        end else if (rises >= 32) begin
            fj   = rises - 32;
            miso = fw[(fj / 16) % 8][15 - (fj % 16)];
        end
    end

    // Memory-side monitor
    logic [3:0]  wa [$];
    logic [15:0] wd [$];
    logic [3:0]  w6a [$];
    logic [15:0] w6d [$];
    int we_bad = 0, done_cnt = 0, done_bad = 0, done6 = 0;

    always @(negedge clk) begin
        if (mem_cs === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_din);
            if (mem_we !== 1'b1) we_bad++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (cs_n !== 1'b1 || busy !== 1'b0) done_bad++;
        end
        if (mcs6 === 1'b1) begin
            w6a.push_back(ma6);
            w6d.push_back(md6);
            if (mwe6 !== 1'b1) we_bad++;
        end
        if (dn6 === 1'b1) done6++;
    end

    task automatic randomize_words();
        for (int i = 0; i < 8; i++) fw[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; st1 = 1'b0; st4 = 1'b0; st6 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (cs_n !== 1'b1)      begin n_err++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        n_cmp++; if (sck !== 1'b0)       begin n_err++; $display("FAIL reset_sck: got %b want 0", sck); end
        n_cmp++; if (mosi !== 1'b0)      begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        n_cmp++; if (mem_cs !== 1'b0)    begin n_err++; $display("FAIL reset_mem_cs: got %b want 0", mem_cs); end
        n_cmp++; if (mem_we !== 1'b0)    begin n_err++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (mem_addr !== 4'h0)  begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_din !== 16'h0)  begin n_err++; $display("FAIL reset_din: got %h want 0", mem_din); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_transfer(input bit fixed_words);
        int base, dbase, cbase, k, nw;
        randomize_words();
        if (fixed_words) begin
            fw[0] = 16'h1234;
            fw[1] = 16'hABCD;
        end
        base = wa.size(); dbase = done_cnt; cbase = cmd_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL xfer_busy: got %b want 1", busy); end
        n_cmp++; if (cs_n !== 1'b0) begin n_err++; $display("FAIL xfer_cs_low: got %b want 0", cs_n); end
        k = 0;
        while (done_cnt == dbase && k < 3000) begin @(posedge clk); k++; end
        n_cmp++; if (done_cnt == dbase) begin n_err++; $display("FAIL xfer_timeout: waited %0d cycles for done", k); end
        repeat (20) @(posedge clk);
        n_cmp++; if (cmd_cnt != cbase + 1 || cmd_last !== 32'h03000000)
            begin n_err++; $display("FAIL xfer_cmd: got %h (%0d cmds) want 03000000", cmd_last, cmd_cnt - cbase); end
        nw = wa.size() - base;
        n_cmp++; if (nw != 8) begin n_err++; $display("FAIL xfer_nwrites: got %0d want 8", nw); end
        for (int i = 0; i < 8; i++) begin
            if (i < nw) begin
                n_cmp++;
                if (wa[base+i] !== 4'((0 + i) % 16) || wd[base+i] !== fw[i]) begin
                    n_err++;
                    $display("FAIL xfer_write%0d: got addr %h data %h want addr %h data %h",
                             i, wa[base+i], wd[base+i], 4'(i), fw[i]);
                end
            end
        end
        n_cmp++; if (done_cnt - dbase != 1) begin n_err++; $display("FAIL xfer_done_cycles: got %0d want 1", done_cnt - dbase); end
        n_cmp++; if (done_bad != 0 || we_bad != 0)
            begin n_err++; $display("FAIL xfer_strobes: done_bad %0d we_bad %0d want 0 0", done_bad, we_bad); end
        @(negedge clk);
        n_cmp++; if (cs_n !== 1'b1 || busy !== 1'b0)
            begin n_err++; $display("FAIL xfer_after: cs_n %b busy %b want 1 0", cs_n, busy); end
    endtask

    task automatic test_clk_div();
        for (int w = 0; w < 2; w++) begin
            int   cd  = (w == 0) ? 1 : 4;
            int   lat = 1;
            int   r1  = -1;
            int   r2  = -1;
            int   k   = 0;
            logic ps  = 1'b0;
            logic s, m;
            @(negedge clk); if (w == 0) st1 = 1'b1; else st4 = 1'b1;
            @(negedge clk); st1 = 1'b0; st4 = 1'b0;
            n_cmp++;
            if (((w == 0) ? csn1 : csn4) !== 1'b0 || ((w == 0) ? mosi1 : mosi4) !== 1'b0) begin
                n_err++; $display("FAIL div%0d_start: cs_n/mosi not 0/0 after start", cd);
            end
            m = (w == 0) ? mcs1 : mcs4;
            while (m !== 1'b1 && lat < 1000) begin
                s = (w == 0) ? sck1 : sck4;
                if (s === 1'b1 && ps === 1'b0) begin
                    if (r1 < 0) r1 = lat;
                    else if (r2 < 0) r2 = lat;
                end
                ps = s;
                @(negedge clk); lat++;
                m = (w == 0) ? mcs1 : mcs4;
            end
            n_cmp++; if (lat != 96 * cd + 2) begin n_err++; $display("FAIL div%0d_latency: got %0d want %0d", cd, lat, 96 * cd + 2); end
            n_cmp++; if (r2 - r1 != 2 * cd) begin n_err++; $display("FAIL div%0d_sck_period: got %0d want %0d", cd, r2 - r1, 2 * cd); end
            n_cmp++;
            if (((w == 0) ? md1 : md4) !== 16'h0 || ((w == 0) ? ma1 : ma4) !== 4'h0 ||
                ((w == 0) ? mwe1 : mwe4) !== 1'b1 || ((w == 0) ? dn1 : dn4) !== 1'b0) begin
                n_err++; $display("FAIL div%0d_first_write: addr/data/we/done not 0/0/1/0", cd);
            end
            while (((w == 0) ? b1 : b4) === 1'b1 && k < 4000) begin @(negedge clk); k++; end
            n_cmp++; if (((w == 0) ? b1 : b4) !== 1'b0) begin n_err++; $display("FAIL div%0d_finish: still busy after %0d cycles", cd, k); end
        end
    endtask

    task automatic test_busy_ignore();
        int base, dbase, k, nw;
        randomize_words();
        base = wa.size(); dbase = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (done_cnt == dbase && k < 3000) begin @(posedge clk); k++; end
        repeat (300) @(posedge clk);
        nw = wa.size() - base;
        n_cmp++; if (nw != 8) begin n_err++; $display("FAIL ignore_nwrites: got %0d want 8", nw); end
        n_cmp++; if (done_cnt - dbase != 1) begin n_err++; $display("FAIL ignore_dones: got %0d want 1", done_cnt - dbase); end
        for (int i = 0; i < 8; i++) begin
            if (i < nw) begin
                n_cmp++;
                if (wd[base+i] !== fw[i]) begin n_err++; $display("FAIL ignore_data%0d: got %h want %h", i, wd[base+i], fw[i]); end
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int base, k, nw;
        randomize_words();
        base = wa.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (wa.size() < base + 3 && k < 3000) begin @(posedge clk); k++; end
        repeat (20) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_cmp++; if (cs_n !== 1'b1)   begin n_err++; $display("FAIL rstmid_cs_n: got %b want 1", cs_n); end
        n_cmp++; if (mem_we !== 1'b0 || mem_cs !== 1'b0)
            begin n_err++; $display("FAIL rstmid_mem: we %b cs %b want 0 0", mem_we, mem_cs); end
        n_cmp++; if (busy !== 1'b0 || sck !== 1'b0)
            begin n_err++; $display("FAIL rstmid_busy_sck: busy %b sck %b want 0 0", busy, sck); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        nw = wa.size() - base;
        n_cmp++; if (nw != 3) begin n_err++; $display("FAIL rstmid_nwrites: got %0d want 3", nw); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: busy %b want 0", busy); end
        for (int i = 0; i < 3; i++) begin
            if (i < nw) begin
                n_cmp++;
                if (wd[base+i] !== fw[i]) begin n_err++; $display("FAIL rstmid_data%0d: got %h want %h", i, wd[base+i], fw[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, dbase, k, nw;
        randomize_words();
        base = wa.size(); dbase = done_cnt;
        @(negedge clk); start = 1'b1;
        k = 0;
        while (done_cnt == dbase && k < 3000) begin @(posedge clk); k++; end
        @(negedge clk); start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart: busy %b want 1", busy); end
        k = 0;
        while (done_cnt < dbase + 2 && k < 3000) begin @(posedge clk); k++; end
        repeat (20) @(posedge clk);
        nw = wa.size() - base;
        n_cmp++; if (nw != 16) begin n_err++; $display("FAIL b2b_nwrites: got %0d want 16", nw); end
        for (int i = 0; i < 16; i++) begin
            if (i < nw) begin
                n_cmp++;
                if (wa[base+i] !== 4'(i % 8) || wd[base+i] !== fw[i % 8]) begin
                    n_err++;
                    $display("FAIL b2b_write%0d: got addr %h data %h want addr %h data %h",
                             i, wa[base+i], wd[base+i], 4'(i % 8), fw[i % 8]);
                end
            end
        end
        n_cmp++; if (done_cnt - dbase != 2) begin n_err++; $display("FAIL b2b_dones: got %0d want 2", done_cnt - dbase); end
    endtask

    task automatic test_single();
        int k = 0;
        @(negedge clk); st6 = 1'b1;
        @(negedge clk); st6 = 1'b0;
        n_cmp++; if (mosi6 !== 1'b0 || csn6 !== 1'b0)
            begin n_err++; $display("FAIL single_start: mosi %b cs_n %b want 0 0", mosi6, csn6); end
        while (done6 == 0 && k < 2000) begin @(posedge clk); k++; end
        repeat (10) @(posedge clk);
        n_cmp++; if (w6a.size() != 1) begin n_err++; $display("FAIL single_nwrites: got %0d want 1", w6a.size()); end
        if (w6a.size() > 0) begin
            n_cmp++;
            if (w6a[0] !== 4'hF || w6d[0] !== 16'hFFFF)
                begin n_err++; $display("FAIL single_write: got addr %h data %h want F FFFF", w6a[0], w6d[0]); end
        end
        n_cmp++; if (done6 != 1) begin n_err++; $display("FAIL single_done: got %0d want 1", done6); end
        n_cmp++; if (b6 !== 1'b0 || csn6 !== 1'b1 || sck6 !== 1'b0)
            begin n_err++; $display("FAIL single_idle: busy %b cs_n %b sck %b want 0 1 0", b6, csn6, sck6); end
        n_cmp++; if (we_bad != 0) begin n_err++; $display("FAIL single_we: we_bad %0d want 0", we_bad); end
    endtask

    initial begin
        test_reset();
        test_transfer(1'b1);
        test_clk_div();
        test_busy_ignore();
        test_reset_mid();
        test_transfer(1'b0);
        test_back_to_back();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
